// File: rtl/input_debouncer_pkg.sv
// Shared defaults for the input debouncer slice.
package input_debouncer_pkg;

    localparam int unsigned DEF_WIDTH     = 4;  // independent input lines
    localparam int unsigned DEF_DB_CYCLES = 4;  // consecutive samples needed to accept a level
    localparam int unsigned DEF_CNT_W     = 3;  // debounce counter width

    // True when a CNT_W-bit counter can hold the terminal count DB_CYCLES-1.
    function automatic bit cnt_fits(input int unsigned cnt_w, input int unsigned db_cycles);
        return (64'(1) << cnt_w) > 64'(db_cycles - 1);
    endfunction

endpackage

// File: rtl/input_debouncer_cell.sv
// One debounced line: 2-flop synchronizer, consecutive-sample counter,
// stable level register and rising-acceptance pulse register.
//   clk, rst      : clock, synchronous active-high reset
//   raw           : asynchronous raw line
//   level         : debounced stable level (registered)
//   press         : one-cycle pulse on accepted 0->1 (registered)
//   level_nxt_c   : combinational next value of level (for same-edge OR in top)
module debounce_cell
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic level_nxt_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept_c;

    // A new level is taken once it has mismatched the stable level for DB_CYCLES samples.
    always_comb begin
        accept_c    = (s2 != level) && (cnt == CNT_LAST);
        level_nxt_c = accept_c ? s2 : level;
    end

    // Synchronizer, filter counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level_nxt_c;
            press <= accept_c & s2;
            if (s2 == level || accept_c) begin
                cnt <= '0;   // glitch discarded, or acceptance completes
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// WIDTH-line debouncer feeding the 4-to-2 encoder stage.
//   clk, rst : clock, synchronous active-high reset
//   raw_in   : asynchronous raw switch lines (bit i -> encoder di)
//   d_out    : debounced stable levels (registered)
//   press    : one-cycle pulses on accepted 0->1 transitions (registered)
//   any_act  : OR of d_out, updated on the same edge as d_out (registered)
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] press,
    output logic             any_act
);

    logic [WIDTH-1:0] d_nxt_c;

    // One independent filter per line.
    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .raw         (raw_in[i]),
            .level       (d_out[i]),
            .press       (press[i]),
            .level_nxt_c (d_nxt_c[i])
        );
    end

    // Activity flag built from next levels so it lines up with d_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_act <= 1'b0;
        end else begin
            any_act <= |d_nxt_c;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
`timescale 1ps/1ps
module tb_input_debouncer;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] d_out;
    logic [W-1:0] press;
    logic         any_act;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    input_debouncer #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .d_out   (d_out),
        .press   (press),
        .any_act (any_act)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the synchronized line is raw delayed two edges; a line flips when its
    // last DB synchronized samples all disagree with the current debounced level.
    logic [W-1:0] m_p1 = '0, m_p2 = '0;
    logic [W-1:0] m_hist [DB];
    logic [W-1:0] m_d = '0, m_press = '0;
    logic         m_any = 1'b0;

    initial for (int k = 0; k < DB; k++) m_hist[k] = '0;

    always @(posedge clk) begin : mdl
        logic [W-1:0] nh [DB];
        logic [W-1:0] nd;
        if (rst) begin
            m_p1 <= '0; m_p2 <= '0;
            for (int k = 0; k < DB; k++) m_hist[k] <= '0;
            m_d <= '0; m_press <= '0; m_any <= 1'b0;
        end else begin
            nh[0] = m_p2;
            for (int k = 1; k < DB; k++) nh[k] = m_hist[k-1];
            for (int i = 0; i < W; i++) begin
                int disagree;
                disagree = 0;
                for (int k = 0; k < DB; k++) if (nh[k][i] != m_d[i]) disagree++;
                nd[i] = (disagree == DB) ? ~m_d[i] : m_d[i];
            end
            for (int k = 0; k < DB; k++) m_hist[k] <= nh[k];
            m_press <= nd & ~m_d;
            m_d     <= nd;
            m_any   <= (nd != '0);
            m_p2    <= m_p1;
            m_p1    <= raw_in;
        end
    end

    // Per-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check_val("d_out", 32'(d_out), 32'(m_d));
            check_val("press", 32'(press), 32'(m_press));
            check_val("any_act", 32'(any_act), 32'(m_any));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for d_out to match target; returns negedges elapsed or -1.
    task automatic wait_d(input logic [W-1:0] target, output int n, output logic [W-1:0] p_at);
        n = -1;
        p_at = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d_out == target) begin
                n = k;
                p_at = press;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] p;
        int pcount;

        // Reset held two cycles with all lines high.
        rst = 1'b1; raw_in = 4'b1111;
        @(posedge clk);
        check_en = 1'b1;
        cycles(2);
        check_val("reset_d", 32'(d_out), 32'h0);
        check_val("reset_any", 32'(any_act), 32'h0);
        raw_in = 4'b0000;
        rst = 1'b0;
        cycles(8);

        // Clean press: 6-cycle latency, single press, any_act coincident.
        raw_in = 4'b0001;
        wait_d(4'b0001, n, p);
        check_val("clean_lat", 32'(n), 32'd6);
        check_val("clean_press", 32'(p), 32'b0001);
        check_val("clean_any", 32'(any_act), 32'd1);
        cycles(1);
        check_val("clean_press_off", 32'(press), 32'h0);
        raw_in = 4'b0000;
        cycles(10);

        // Glitch of 3 cycles never propagates.
        raw_in = 4'b0100;
        cycles(3);
        raw_in = 4'b0000;
        cycles(10);
        check_val("glitch_d", 32'(d_out), 32'h0);

        // Bounce then hold high: one press, then release with no press.
        pcount = 0;
        raw_in = 4'b0010; cycles(1);
        raw_in = 4'b0000; cycles(1);
        raw_in = 4'b0010; cycles(1);
        raw_in = 4'b0000; cycles(1);
        raw_in = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (press[1]) pcount++;
            if (k < 6) check_val("bounce_early", 32'(d_out[1]), 32'd0);
        end
        check_val("bounce_d", 32'(d_out[1]), 32'd1);
        cycles(6);
        check_val("bounce_presses", 32'(pcount), 32'd1);
        raw_in = 4'b0000;
        wait_d(4'b0000, n, p);
        check_val("release_lat", 32'(n), 32'd6);
        check_val("release_press", 32'(p), 32'h0);
        cycles(4);

        // Simultaneous acceptance on two lines.
        raw_in = 4'b1010;
        wait_d(4'b1010, n, p);
        check_val("simul_lat", 32'(n), 32'd6);
        check_val("simul_press", 32'(p), 32'b1010);
        raw_in = 4'b0000;
        cycles(10);

        // Reset while pending discards the change; re-accepted after release.
        raw_in = 4'b0100;
        cycles(4);
        rst = 1'b1;
        cycles(1);
        check_val("midrst_d", 32'(d_out), 32'h0);
        rst = 1'b0;
        wait_d(4'b0100, n, p);
        check_val("midrst_lat", 32'(n), 32'd6);
        check_val("midrst_press", 32'(p), 32'b0100);
        raw_in = 4'b0000;
        cycles(10);

        // Sweep of every pattern held long enough to settle.
        for (int v = 0; v < 16; v++) begin
            raw_in = W'(v);
            cycles(10);
            check_val("sweep", 32'(d_out), 32'(v));
        end

        // Random bouncing lines with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] flip;
            for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 5) == 0);
            raw_in = raw_in ^ flip;
            rst = ($urandom_range(0, 199) == 0);
            cycles(1);
        end
        rst = 1'b0;
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
